// File: rtl/hex_matrix_rx_if.sv
// Receive/readback bundle of the hex token parser: byte strobe in, value
// buffer read port and status flags out.
interface hex_matrix_rx_if;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rx_error;
  logic [3:0]  rd_addr;
  logic [17:0] rd_data;
  logic [4:0]  value_count;
  logic        busy;
  logic        done;
  logic        parse_error;

  modport master (
    output rx_valid, rx_byte, rx_error, rd_addr,
    input  rd_data, value_count, busy, done, parse_error
  );

  modport slave (
    input  rx_valid, rx_byte, rx_error, rd_addr,
    output rd_data, value_count, busy, done, parse_error
  );
endinterface

// File: rtl/hex_matrix_rx.sv
// Parses a UART stream of whitespace-delimited ASCII hex tokens into a buffer
// of 18-bit values; stops at NUM_VALUES values or on the first malformed input.
module hex_matrix_rx #(
  parameter int NUM_VALUES = 16,
  parameter int MAX_DIGITS = 5
) (
  input logic            clk,
  input logic            reset,
  input logic            clear,
  hex_matrix_rx_if.slave bus
);

  typedef enum logic [1:0] {S_SKIP, S_ACCUM, S_DONE, S_ERR} state_t;

  localparam int AW    = (NUM_VALUES > 1) ? $clog2(NUM_VALUES) : 1;
  localparam int CNT_W = $clog2(MAX_DIGITS + 2);

  state_t           r_state, w_state_nxt;
  logic [19:0]      r_acc, w_acc_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [4:0]       r_count;
  logic [17:0]      r_buf [NUM_VALUES];
  logic             w_store;
  logic             w_is_digit;
  logic             w_is_delim;
  logic [3:0]       w_nibble;
  logic [AW-1:0]    w_rd_idx;

  always_comb begin
    w_is_digit = 1'b0;
    w_nibble   = 4'h0;
    if (bus.rx_byte >= 8'h30 && bus.rx_byte <= 8'h39) begin
      w_is_digit = 1'b1;
      w_nibble   = bus.rx_byte[3:0];
    end else if ((bus.rx_byte >= 8'h41 && bus.rx_byte <= 8'h46) ||
                 (bus.rx_byte >= 8'h61 && bus.rx_byte <= 8'h66)) begin
      // Low nibble of 'A'/'a' is 1, so +9 yields 10..15.
      w_is_digit = 1'b1;
      w_nibble   = bus.rx_byte[3:0] + 4'd9;
    end
    w_is_delim = (bus.rx_byte == 8'h20) || (bus.rx_byte == 8'h0D) ||
                 (bus.rx_byte == 8'h0A);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_store     = 1'b0;
    if (bus.rx_valid) begin
      case (r_state)
        S_SKIP: begin
          if (bus.rx_error) begin
            w_state_nxt = S_ERR;
          end else if (w_is_digit) begin
            w_acc_nxt   = {16'h0000, w_nibble};
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = S_ACCUM;
          end else if (!w_is_delim) begin
            w_state_nxt = S_ERR;
          end
        end
        S_ACCUM: begin
          if (bus.rx_error) begin
            w_state_nxt = S_ERR;
          end else if (w_is_digit) begin
            if (int'(r_cnt) >= MAX_DIGITS) begin
              w_state_nxt = S_ERR;
            end else begin
              w_acc_nxt = {r_acc[15:0], w_nibble};
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end else if (w_is_delim) begin
            if (r_acc[19:18] != 2'b00) begin
              w_state_nxt = S_ERR;
            end else begin
              w_store     = 1'b1;
              w_acc_nxt   = '0;
              w_cnt_nxt   = '0;
              w_state_nxt = (int'(r_count) + 1 == NUM_VALUES) ? S_DONE : S_SKIP;
            end
          end else begin
            w_state_nxt = S_ERR;
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Clear is a full restart, so it also wipes the buffer and wins over rx_valid.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      r_state <= S_SKIP;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_count <= '0;
      for (int i = 0; i < NUM_VALUES; i++) r_buf[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_store) begin
        r_buf[r_count[AW-1:0]] <= r_acc[17:0];
        r_count                <= r_count + 5'd1;
      end
    end
  end

  assign w_rd_idx        = AW'(bus.rd_addr);
  assign bus.rd_data     = ({1'b0, bus.rd_addr} < r_count) ? r_buf[w_rd_idx] : 18'h0;
  assign bus.value_count = r_count;
  assign bus.busy        = (r_state == S_ACCUM);
  assign bus.done        = (r_state == S_DONE);
  assign bus.parse_error = (r_state == S_ERR);

endmodule

// File: doc/hex_matrix_rx.md
HEX_MATRIX_RX -- requirements
Module: hex_matrix_rx

Interface
REQ-001 SHALL have parameter NUM_VALUES, default 16: number of values to collect before completion.
REQ-002 SHALL have parameter MAX_DIGITS, default 5: maximum hex digits per token.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous reset, active-low.
REQ-005 SHALL have port clear  input  1  synchronous restart pulse, active-high.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe: rx_byte holds a received character.
REQ-007 SHALL have port rx_byte  input  8  received ASCII character.
REQ-008 SHALL have port rx_error  input  1  UART framing error, qualified by rx_valid.
REQ-009 SHALL have port rd_addr  input  4  read index into the value buffer.
REQ-010 SHALL have port rd_data  output  18  buffer[rd_addr], combinational read.
REQ-011 SHALL have port value_count  output  5  number of values stored so far.
REQ-012 SHALL have port busy  output  1  high while a token is being accumulated.
REQ-013 SHALL have port done  output  1  high once NUM_VALUES values are stored.
REQ-014 SHALL have port parse_error  output  1  sticky error flag.

Function
REQ-015 SHALL parse a stream of ASCII hex tokens; digits '0'-'9', 'A'-'F', 'a'-'f' map to nibble values 0-15.
REQ-016 SHALL treat 0x20 (space), 0x0D (CR), 0x0A (LF) as delimiters; consecutive delimiters produce no value.
REQ-017 SHALL implement FSM states S_SKIP, S_ACCUM, S_DONE, S_ERR; reset and clear enter S_SKIP.
REQ-018 S_SKIP: on a delimiter, stay; on a digit, load acc = nibble, digit count = 1, go to S_ACCUM.
REQ-019 S_ACCUM: on a digit, acc = {acc, nibble} with 20-bit internal width, digit count +1.
REQ-020 S_ACCUM: on a delimiter, if acc[19:18] == 0, write acc[17:0] to buffer[value_count], increment value_count, then go to S_SKIP, or to S_DONE if the new count equals NUM_VALUES.
REQ-021 The following SHALL move the FSM to S_ERR and set parse_error: a token with acc[19:18] != 0, a digit count exceeding MAX_DIGITS, any non-hex non-delimiter character, or rx_valid together with rx_error (in any state except S_DONE).
REQ-022 S_DONE and S_ERR SHALL ignore all input bytes until reset or clear; buffer contents SHALL be retained.
REQ-023 A store SHALL be visible on rd_data and value_count the cycle after the rx_valid edge of the terminating delimiter; done SHALL assert in that same cycle.
REQ-024 busy SHALL equal (state == S_ACCUM); done SHALL equal (state == S_DONE); parse_error SHALL equal (state == S_ERR).
REQ-025 Cycles without rx_valid SHALL change no state; back-to-back rx_valid on consecutive cycles SHALL each be processed.
REQ-026 If clear and rx_valid are high in the same cycle, clear SHALL win and the byte SHALL be dropped.
REQ-027 A token that is not terminated, with the stream idle, SHALL NOT be stored.
REQ-028 rd_addr values at or above value_count SHALL return the cleared value 0.

Reset
REQ-029 With reset low at a clock edge, the block SHALL enter S_SKIP and set value_count=0, acc=0, digit count=0, all buffer entries=0, busy=0, done=0, parse_error=0.
REQ-030 clear SHALL have the same effect as reset; a reset or clear mid-token SHALL discard the partial token.

Verification
REQ-031 Input "1 2F 3ffff\r\n" -> buffer[0..2] = 0x00001, 0x0002F, 0x3FFFF; value_count=3; done=0; parse_error=0.
REQ-032 Input of 16 tokens "0".."F" separated by single spaces plus a trailing space -> done=1 one cycle after the final space; buffer[i]=i; a further "7 " -> no change.
REQ-033 Input "40000 " -> parse_error=1, value_count=0; "000001 " with MAX_DIGITS=5 -> parse_error=1.
REQ-034 Input "12 G" -> buffer[0]=0x12, parse_error=1 after 'G'; then clear pulse, then "5 " -> value_count=1, buffer[0]=0x5, parse_error=0.
REQ-035 Input "AB" with rx_valid/rx_error high on 'B' -> parse_error=1, value_count=0; reset low for one cycle while busy=1 -> all outputs 0.
REQ-036 "1 2" fed with rx_valid strobes on consecutive cycles, then "  \n" -> value_count=2, buffer[1]=0x2, with no extra values from the repeated delimiters.
